traffic_sensor_conditioner: RTL



---
 rtl/traffic_pkg.sv | 16 +
 rtl/sensor_debounce.sv | 153 +++++++++++++++
 rtl/traffic_sensor_conditioner.sv | 66 ++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor conditioner: debounce state
// encoding and default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } deb_state_e;

  localparam int TICK_DIV_DEF       = 4;
  localparam int DEBOUNCE_TICKS_DEF = 3;
  localparam int STUCK_TICKS_DEF    = 64;

endpackage

// File: rtl/sensor_debounce.sv
// One loop-detector channel: 2-flop synchroniser, tick-gated debounce FSM and,
// when TRAFFIC_STUCK_DETECT_EN is defined, a stuck-high detector that raises
// fault_o and masks sensor_o.
//
// state        | meaning
// ST_LOW       | clean level 0, waiting for s2=1
// ST_RISE_PEND | s2=1 seen, counting ticks before output rises
// ST_HIGH      | clean level 1, waiting for s2=0
// ST_FALL_PEND | s2=0 seen, counting ticks before output falls
import traffic_pkg::*;

module sensor_debounce #(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int STUCK_TICKS    = STUCK_TICKS_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic sensor_o,
  output logic fault_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic            s1_q, s2_q;
  deb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sensor_q, sensor_d;
  logic            in_high_d;

  // Next-state for the debounce FSM; only advances on a sampling tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      case (state_q)
        ST_LOW: begin
          if (s2_q) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else begin
              state_d = ST_RISE_PEND;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_RISE_PEND: begin
          if (!s2_q) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!s2_q) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else begin
              state_d = ST_FALL_PEND;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_FALL_PEND: begin
          if (s2_q) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign in_high_d = (state_d == ST_HIGH) || (state_d == ST_FALL_PEND);

  // Synchroniser, FSM state and registered clean output.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      sensor_q <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sensor_q <= sensor_d;
    end
  end

`ifdef TRAFFIC_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_TICKS + 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS);

  logic [SW-1:0] stuck_q, stuck_d;
  logic          fault_q, fault_d;

  // Stuck counter runs only while HIGH; the fault holds through FALL_PEND
  // and is released only once the channel settles back to LOW.
  always_comb begin
    stuck_d = stuck_q;
    fault_d = fault_q;
    if (tick_i) begin
      if (state_q == ST_HIGH) begin
        if (stuck_q != STUCK_LAST) stuck_d = stuck_q + SW'(1);
      end else begin
        stuck_d = '0;
      end
    end
    if (stuck_d == STUCK_LAST) fault_d = 1'b1;
    if (state_d == ST_LOW)     fault_d = 1'b0;
  end

  // Stuck counter and fault flag registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign sensor_d = in_high_d & ~fault_d;
  assign fault_o  = fault_q;
`else
  assign sensor_d = in_high_d;
  assign fault_o  = 1'b0;
`endif

  assign sensor_o = sensor_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Traffic sensor front end: shared sampling-tick prescaler plus one debounce
// channel each for NS and EW. Stuck detection is built in when
// TRAFFIC_STUCK_DETECT_EN is defined.
import traffic_pkg::*;

module traffic_sensor_conditioner #(
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int STUCK_TICKS    = STUCK_TICKS_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic NS_raw,
  input  logic EW_raw,
  output logic NS_sensor,
  output logic EW_sensor,
  output logic Tick,
  output logic NS_fault,
  output logic EW_fault
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_q;
  logic          tick_q;

  // Prescaler; the strobe is registered so it first shows after the
  // TICK_DIV-th edge out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
      tick_q <= (ps_q == PS_LAST);
    end
  end

  assign Tick = tick_q;

  sensor_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .STUCK_TICKS    (STUCK_TICKS)
  ) u_ns (
    .Clock    (Clock),
    .Reset    (Reset),
    .tick_i   (tick_q),
    .raw_i    (NS_raw),
    .sensor_o (NS_sensor),
    .fault_o  (NS_fault)
  );

  sensor_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .STUCK_TICKS    (STUCK_TICKS)
  ) u_ew (
    .Clock    (Clock),
    .Reset    (Reset),
    .tick_i   (tick_q),
    .raw_i    (EW_raw),
    .sensor_o (EW_sensor),
    .fault_o  (EW_fault)
  );

endmodule
